// File: rtl/note_feeder.sv
// Chart sequencer for the 5-bit note shifter: clears it at song start, then emits one ROM note and one shift pulse per tempo tick, and drains five empty slots at the end.
// All outputs except rom_addr/load_val are registered; pause freezes the tempo, and abort wipes the shifter and returns to idle without a done pulse.
module note_feeder #(
    parameter int TICK_DIV  = 12500000,
    parameter int CHART_LEN = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic [4:0]        load_val,
    output logic              load_n,
    output logic              note_bit,
    output logic              shift,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  TERM = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CHART_LEN - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [2:0]        r_drain;
    logic              r_abort;
    logic              w_play;
    logic              w_tick;

    assign rom_addr = r_idx;
    assign load_val = 5'b00000;

    // Abort and pause both suppress a tick that lands on the terminal count.
    assign w_play = (r_state == RUN) || (r_state == DRAIN);
    assign w_tick = w_play && !abort && !pause && (r_cnt == TERM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = CLEAR;
            CLEAR: w_next = r_abort ? IDLE : RUN;
            RUN: begin
                if (abort)
                    w_next = CLEAR;
                else if (w_tick && (r_idx == LAST))
                    w_next = DRAIN;
            end
            DRAIN: begin
                if (abort)
                    w_next = CLEAR;
                else if (w_tick && (r_drain == 3'd4))
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_drain  <= '0;
            r_abort  <= 1'b0;
            load_n   <= 1'b1;
            shift    <= 1'b0;
            note_bit <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state <= w_next;
            load_n  <= (w_next != CLEAR);
            busy    <= (w_next != IDLE);
            done    <= (r_state == DONE);
            shift   <= w_tick;
            if (w_tick)
                note_bit <= (r_state == RUN) ? rom_data : 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_drain <= '0;
                        r_abort <= 1'b0;
                    end
                end
                // The CLEAR cycle counts toward the first tick so the first
                // shift lands exactly TICK_DIV cycles after the load pulse.
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_idx <= '0;
                end
                RUN, DRAIN: begin
                    if (abort) begin
                        r_abort <= 1'b1;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else if (!pause) begin
                        r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
                        if (w_tick) begin
                            if (r_state == RUN)
                                r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
                            else
                                r_drain <= r_drain + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_note_feeder.sv
// Directed bench for note_feeder: a 4-entry/4-clock instance and a 1-entry/2-clock instance share stimulus.
module tb_note_feeder;
    logic clock = 1'b0;
    logic reset, start, abort, pause;
    always #5 clock = ~clock;

    logic [1:0] addr_a;
    logic       rd_a, ldn_a, nb_a, sh_a, busy_a, done_a;
    logic [4:0] lv_a;
    logic [0:0] addr_b;
    logic       rd_b, ldn_b, nb_b, sh_b, busy_b, done_b;
    logic [4:0] lv_b;

    logic [3:0] rom_a;
    logic [1:0] rom_b;
    initial begin
        rom_a = 4'b1101;   // entries 0..3 = 1,0,1,1
        rom_b = 2'b01;     // entry 0 = 1
    end
    always_ff @(posedge clock) begin
        rd_a <= rom_a[addr_a];
        rd_b <= rom_b[addr_b];
    end

    note_feeder #(.TICK_DIV(4), .CHART_LEN(4), .ADDR_W(2)) dut_a (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .pause(pause),
        .rom_addr(addr_a), .rom_data(rd_a), .load_val(lv_a), .load_n(ldn_a),
        .note_bit(nb_a), .shift(sh_a), .busy(busy_a), .done(done_a));

    note_feeder #(.TICK_DIV(2), .CHART_LEN(1), .ADDR_W(1)) dut_b (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .pause(pause),
        .rom_addr(addr_b), .rom_data(rd_b), .load_val(lv_b), .load_n(ldn_b),
        .note_bit(nb_b), .shift(sh_b), .busy(busy_b), .done(done_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         sel;        // 0 = dut_a, 1 = dut_b
        logic       hold;       // keep start high throughout
        int         start_t;    // extra one-cycle start pulse (-1 none)
        int         pause_t;    // pause high for 10 cycles from here (-1 none)
        int         abort_t;    // one-cycle abort (-1 none)
        int         win;        // observation window in cycles
        int         per;        // expected tick spacing
        int         pdel;       // extra delay from shift index 2 onward
        int         exp_n;      // expected shifts in window
        logic [8:0] notes;      // expected note_bit, bit k for shift k
        int         done_t;     // expected done cycle (-1 none)
        int         ld2_t;      // expected second load_n=0 cycle (-1 none)
        int         bfall_t;    // expected first busy=0 cycle
    } vec_t;

    task automatic run_vec(input int id, input vec_t v);
        int   sh_t[$];
        logic sh_n[$];
        int   done_t = -1, ndone = 0, ld_first = -1, ld2 = -1, bfall = -1;
        logic s, nb, ldn, b, d;
        int   lim;
        @(negedge clock);
        start = 1'b1;
        for (int t = 0; t < v.win; t++) begin
            @(negedge clock);
            if (v.sel == 0) {s, nb, ldn, b, d} = {sh_a, nb_a, ldn_a, busy_a, done_a};
            else            {s, nb, ldn, b, d} = {sh_b, nb_b, ldn_b, busy_b, done_b};
            if (s) begin
                sh_t.push_back(t);
                sh_n.push_back(nb);
            end
            if (d) begin
                ndone++;
                if (done_t < 0) done_t = t;
            end
            if (!ldn) begin
                if (t == 0) ld_first = 0;
                else if (ld2 < 0) ld2 = t;
            end
            if (!b && bfall < 0) bfall = t;
            start = v.hold || (t == v.start_t);
            pause = (v.pause_t >= 0) && (t >= v.pause_t) && (t < v.pause_t + 10);
            abort = (t == v.abort_t);
        end
        check($sformatf("v%0d load_n low at start", id), ld_first, 0);
        check($sformatf("v%0d shift count", id), sh_t.size(), v.exp_n);
        lim = (sh_t.size() < v.exp_n) ? sh_t.size() : v.exp_n;
        for (int k = 0; k < lim; k++) begin
            check($sformatf("v%0d shift%0d cycle", id, k), sh_t[k],
                  v.per * (k + 1) + ((k >= 2) ? v.pdel : 0));
            check($sformatf("v%0d shift%0d note", id, k), int'(sh_n[k]), int'(v.notes[k]));
        end
        check($sformatf("v%0d done count", id), ndone, (v.done_t >= 0) ? 1 : 0);
        check($sformatf("v%0d done cycle", id), done_t, v.done_t);
        check($sformatf("v%0d second load cycle", id), ld2, v.ld2_t);
        check($sformatf("v%0d busy fall cycle", id), bfall, v.bfall_t);
        // return both instances to IDLE
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        repeat (20) @(negedge clock);
    endtask

    vec_t vecs[5];

    initial begin
        //          sel hold st  pau ab  win per pd n  notes         done ld2 bfall
        vecs[0] = '{0, 1'b0, 10, -1, -1, 50, 4, 0,  9, 9'b000001101, 37, -1, 37};
        vecs[1] = '{0, 1'b0, -1,  8, -1, 50, 4, 10, 9, 9'b000001101, 47, -1, 47};
        vecs[2] = '{0, 1'b0, -1, -1,  8, 50, 4, 0,  2, 9'b000000001, -1,  9, 10};
        vecs[3] = '{0, 1'b1, -1, -1, -1, 40, 4, 0,  9, 9'b000001101, 37, 38, 37};
        vecs[4] = '{1, 1'b0, -1, -1, -1, 20, 2, 0,  6, 9'b000000001, 13, -1, 13};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        #3;
        check("reset load_n", int'(ldn_a), 1);
        check("reset shift", int'(sh_a), 0);
        check("reset note_bit", int'(nb_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset done", int'(done_a), 0);
        check("reset rom_addr", int'(addr_a), 0);
        check("load_val", int'(lv_a), 0);
        check("reset busy b", int'(busy_b), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Async reset between edges while dut_a is in DRAIN with a shift pulse high.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        check("pre-reset drain shift", int'(sh_a), 1);
        check("pre-reset busy", int'(busy_a), 1);
        #2 reset = 1'b1;
        #1;
        check("async reset shift", int'(sh_a), 0);
        check("async reset busy", int'(busy_a), 0);
        check("async reset load_n", int'(ldn_a), 1);
        check("async reset done", int'(done_a), 0);
        check("async reset rom_addr", int'(addr_a), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        run_vec(5, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
